// File: rtl/rf_wport_arb_pkg.sv
// Shared types for the register-file write-port arbiter: write-back request
// record, FSM state encoding and long-unit constants.
package rf_wport_arb_pkg;

    typedef struct packed {
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] pc;
    } wb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    // Long-unit results always write the full word.
    localparam logic [3:0] LU_WE    = 4'hF;
    localparam logic [3:0] WAIT_SAT = 4'd15;

endpackage

// File: rtl/rf_wport_fifo.sv
// Result buffer for long-latency unit write-backs; DEPTH must be a power of two.
// No bypass: a pushed entry becomes visible at head on the following cycle.
module rf_wport_fifo
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: main pipeline has priority, buffered
// long-unit results drain when the port is free; starvation forces a hold.
// Define RF_WPORT_DEBUG_EN to drive the debug_wb_* trace outputs.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [3:0]  pipe_we,
    input  logic [4:0]  pipe_wnum,
    input  logic [31:0] pipe_wdata,
    input  logic [31:0] pipe_pc,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wnum,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic        lu_ready,
    output logic        hold_req,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_wnum,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    wb_req_t     lu_req;
    wb_req_t     head;
    wb_req_t     grant_req;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic        pipe_live;
    logic        push;
    logic        pop;
    logic        grant;
    arb_state_t  state;
    logic [3:0]  wait_cnt;
    logic [3:0]  cnt_inc;

    assign lu_req    = '{we: LU_WE, wnum: lu_wnum, wdata: lu_wdata, pc: lu_pc};
    assign pipe_live = pipe_valid && (pipe_we != '0);
    assign lu_ready  = !full;
    assign push      = lu_valid && !full;
    assign pop       = !pipe_live && !empty;
    assign grant     = pipe_live || !empty;
    assign cnt_inc   = (wait_cnt == WAIT_SAT) ? WAIT_SAT : wait_cnt + 4'd1;

    always_comb begin
        grant_req = head;
        if (pipe_live) begin
            grant_req = '{we: pipe_we, wnum: pipe_wnum, wdata: pipe_wdata, pc: pipe_pc};
        end
    end

    rf_wport_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (lu_req),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !grant) begin
            rf_we    <= '0;
            rf_wnum  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= grant_req.we;
            rf_wnum  <= grant_req.wnum;
            rf_wdata <= grant_req.wdata;
        end
    end

    // hold_req is set alongside the FORCE transition so it mirrors the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            hold_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (push) state <= ST_WAIT;
                end
                ST_WAIT, ST_FORCE: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        hold_req <= 1'b0;
                        state    <= (count == CW'(1) && !push) ? ST_IDLE : ST_WAIT;
                    end else if (state == ST_WAIT) begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc >= 4'(STARVE_MAX)) begin
                            state    <= ST_FORCE;
                            hold_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                    hold_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_WPORT_DEBUG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_rf_wen   <= grant ? grant_req.we    : '0;
            debug_wb_rf_wnum  <= grant ? grant_req.wnum  : '0;
            debug_wb_rf_wdata <= grant ? grant_req.wdata : '0;
            if (grant) debug_wb_pc <= grant_req.pc;
        end
    end
`else
    logic unused_pc;
    assign unused_pc         = ^grant_req.pc;
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Scoreboard bench for rf_wport_arb: the driver queues hand-computed post-edge
// expectations each cycle; a monitor pops and compares them after every edge.
module tb_rf_wport_arb;
    import rf_wport_arb_pkg::*;

`ifdef RF_WPORT_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [3:0]  pipe_we;
    logic [4:0]  pipe_wnum;
    logic [31:0] pipe_wdata;
    logic [31:0] pipe_pc;
    logic        lu_valid;
    logic [4:0]  lu_wnum;
    logic [31:0] lu_wdata;
    logic [31:0] lu_pc;
    logic        lu_ready;
    logic        hold_req;
    logic [3:0]  rf_we;
    logic [4:0]  rf_wnum;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    typedef struct packed {
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        hold;
        logic        ready;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] dpc      = '0;

    rf_wport_arb #(.STARVE_MAX(4), .BUF_DEPTH(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pipe_valid        (pipe_valid),
        .pipe_we           (pipe_we),
        .pipe_wnum         (pipe_wnum),
        .pipe_wdata        (pipe_wdata),
        .pipe_pc           (pipe_pc),
        .lu_valid          (lu_valid),
        .lu_wnum           (lu_wnum),
        .lu_wdata          (lu_wdata),
        .lu_pc             (lu_pc),
        .lu_ready          (lu_ready),
        .hold_req          (hold_req),
        .rf_we             (rf_we),
        .rf_wnum           (rf_wnum),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs, queue what the outputs must show after the edge.
    task automatic cyc(
        input logic rn, input logic pv, input logic [3:0] pwe, input logic [4:0] pwn,
        input logic [31:0] pwd, input logic [31:0] ppc,
        input logic lv, input logic [4:0] lwn, input logic [31:0] lwd, input logic [31:0] lpc,
        input logic [3:0] ewe, input logic [4:0] ewn, input logic [31:0] ewd,
        input logic [31:0] epc, input logic eh, input logic er);
        exp_t e;
        rst_n = rn; pipe_valid = pv; pipe_we = pwe; pipe_wnum = pwn;
        pipe_wdata = pwd; pipe_pc = ppc;
        lu_valid = lv; lu_wnum = lwn; lu_wdata = lwd; lu_pc = lpc;
        if (!rn)            dpc = '0;
        else if (ewe != '0) dpc = epc;
        e = '{we: ewe, wnum: ewn, wdata: ewd, pc: dpc, hold: eh, ready: er};
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rf_we",    32'(rf_we),    32'(e.we));
                chk("rf_wnum",  32'(rf_wnum),  32'(e.wnum));
                chk("rf_wdata", rf_wdata,      e.wdata);
                chk("hold_req", 32'(hold_req), 32'(e.hold));
                chk("lu_ready", 32'(lu_ready), 32'(e.ready));
                chk("dbg_wen",  32'(debug_wb_rf_wen),  DBG ? 32'(e.we)   : 32'd0);
                chk("dbg_wnum", 32'(debug_wb_rf_wnum), DBG ? 32'(e.wnum) : 32'd0);
                chk("dbg_wdata", debug_wb_rf_wdata,    DBG ? e.wdata     : 32'd0);
                chk("dbg_pc",   debug_wb_pc,           DBG ? e.pc        : 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // reset
        cyc(0, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);
        cyc(0, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        // single long-unit offer, pipe idle: commits two cycles after offer
        cyc(1, 0,4'h0,0,0,0,            1,8,32'h1234,32'h100,  4'h0,0,0,0,             0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'hF,8,32'h1234,32'h100,0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        // starvation: pipe live every cycle, hold after four waiting cycles
        cyc(1, 1,4'hF,1,32'hA0,32'h200, 1,9,32'h99,32'h300,    4'hF,1,32'hA0,32'h200,  0,1);
        cyc(1, 1,4'hF,9,32'hA1,32'h204, 0,0,0,0,               4'hF,9,32'hA1,32'h204,  0,1);
        cyc(1, 1,4'h3,3,32'hA2,32'h208, 0,0,0,0,               4'h3,3,32'hA2,32'h208,  0,1);
        cyc(1, 1,4'hF,4,32'hA3,32'h20C, 0,0,0,0,               4'hF,4,32'hA3,32'h20C,  0,1);
        cyc(1, 1,4'hF,5,32'hA4,32'h210, 0,0,0,0,               4'hF,5,32'hA4,32'h210,  1,1);
        cyc(1, 1,4'hF,6,32'hA5,32'h214, 0,0,0,0,               4'hF,6,32'hA5,32'h214,  1,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'hF,9,32'h99,32'h300,  0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        // fill buffer, third offer refused, full+pop accepts nothing, drain in order
        cyc(1, 1,4'hF,1,32'hB0,32'h220, 1,10,32'hAAAA,32'h400, 4'hF,1,32'hB0,32'h220,  0,1);
        cyc(1, 1,4'hF,2,32'hB1,32'h224, 1,11,32'hBBBB,32'h404, 4'hF,2,32'hB1,32'h224,  0,0);
        cyc(1, 1,4'hF,3,32'hB2,32'h228, 1,12,32'hCCCC,32'h408, 4'hF,3,32'hB2,32'h228,  0,0);
        cyc(1, 0,4'h0,0,0,0,            1,12,32'hCCCC,32'h408, 4'hF,10,32'hAAAA,32'h400,0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'hF,11,32'hBBBB,32'h404,0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        // pipe_valid with no byte enables: no bypass on push, head drains next cycle
        cyc(1, 1,4'h0,3,32'hDEAD,32'h230, 1,12,32'hC0DE,32'h500, 4'h0,0,0,0,           0,1);
        cyc(1, 1,4'h0,3,32'hDEAD,32'h234, 0,0,0,0,             4'hF,12,32'hC0DE,32'h500,0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        // full buffer with hold asserted, then reset mid-operation
        cyc(1, 1,4'hF,1,32'hE0,32'h240, 1,13,32'h1313,32'h600, 4'hF,1,32'hE0,32'h240,  0,1);
        cyc(1, 1,4'hF,2,32'hE1,32'h244, 1,14,32'h1414,32'h604, 4'hF,2,32'hE1,32'h244,  0,0);
        cyc(1, 1,4'hF,3,32'hE2,32'h248, 0,0,0,0,               4'hF,3,32'hE2,32'h248,  0,0);
        cyc(1, 1,4'hF,4,32'hE3,32'h24C, 0,0,0,0,               4'hF,4,32'hE3,32'h24C,  0,0);
        cyc(1, 1,4'hF,5,32'hE4,32'h250, 0,0,0,0,               4'hF,5,32'hE4,32'h250,  1,0);
        cyc(0, 1,4'hF,6,32'hE5,32'h254, 0,0,0,0,               4'h0,0,0,0,             0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);
        cyc(1, 0,4'h0,0,0,0,            0,0,0,0,               4'h0,0,0,0,             0,1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, cycles a buffered long-unit result may wait before a pipeline hold is forced (legal range 1..15).
REQ-002 Parameter: BUF_DEPTH, default 2, long-unit result buffer entries (power of two, 2..4).
REQ-003 clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 pipe_valid, pipe_we, pipe_wnum, pipe_wdata, pipe_pc  in  1/4/5/32/32  main-pipeline write-back request, byte-enable write.
REQ-006 lu_valid, lu_wnum, lu_wdata, lu_pc  in  1/5/32/32  long-latency unit (mul/div) result offer.
REQ-007 lu_ready  out  1  buffer can accept; transfer when lu_valid && lu_ready.
REQ-008 hold_req  out  1  request to pipeline to insert one bubble at write-back.
REQ-009 rf_we, rf_wnum, rf_wdata  out  4/5/32  registered register-file write port.
REQ-010 debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  32/4/5/32  trace of the committed write.

Function
REQ-011 Pipe request is live when pipe_valid && pipe_we!=0; pipe_valid with pipe_we==0 does not occupy the port.
REQ-012 Long-unit offers enter a FIFO of BUF_DEPTH; lu_ready = !full, combinational from registered state only.
REQ-013 Grant each cycle: live pipe request wins; otherwise FIFO head wins if non-empty; otherwise no write.
REQ-014 Granted write appears on rf_*/debug_* exactly 1 cycle later; no grant -> rf_we=0, rf_wnum=0, rf_wdata=0 next cycle; debug_wb_pc holds its last value.
REQ-015 FIFO full with simultaneous pop: lu_ready stays 0 that cycle; no push occurs.
REQ-016 FIFO empty with push: entry is not grantable before the following cycle (no bypass).
REQ-017 FSM states IDLE (FIFO empty), WAIT (head pending), FORCE (hold asserted).
REQ-018 IDLE->WAIT on push; WAIT->IDLE when last entry popped; WAIT->FORCE when wait_cnt reaches STARVE_MAX; FORCE->WAIT/IDLE after head popped.
REQ-019 wait_cnt (4 bits) increments each WAIT cycle the head is not granted, clears on every head pop, saturates at 15.
REQ-020 hold_req = (state==FORCE), registered.
REQ-021 In FORCE, a live pipe request still wins (pipe is never dropped); FSM stays in FORCE until head is granted.
REQ-022 Pipe and head targeting same wnum in one cycle: pipe wins; head written later in program-order-agnostic fashion; issue logic guarantees no WAW between them.

Reset
REQ-023 Under rst_n=0: FIFO empty, state IDLE, wait_cnt=0, hold_req=0, rf_*=0, all debug_* =0, lu_ready=1 after the first post-reset cycle.
REQ-024 Reset mid-operation discards buffered results and any pending hold without a partial write.

Configuration
REQ-025 Macro RF_WPORT_DEBUG_EN: defined -> debug_* driven per REQ-014; undefined -> debug_* tied to 0 and their registers omitted.

Structure
REQ-026 Shared package holds typedef wb_req_t {we[3:0], wnum[4:0], wdata[31:0], pc[31:0]} and FSM state encodings.
REQ-027 FIFO is a sub-module rf_wport_fifo (parameter DEPTH, push/pop/full/empty/head).

Verification
REQ-028 Single lu offer (wnum=8, wdata=0x1234) with pipe idle -> accepted, rf_we=4'hF, rf_wnum=8 two cycles after offer.
REQ-029 Pipe live every cycle, one lu entry buffered, STARVE_MAX=4 -> hold_req=1 after 4 waiting cycles; on pipe_valid=0 next cycle the entry commits, hold_req drops.
REQ-030 Two lu offers back-to-back with pipe live -> lu_ready=0 on third offer; pops in order when pipe idles.
REQ-031 pipe_valid=1, pipe_we=0 while head buffered -> head committed next cycle.
REQ-032 Assert rst_n=0 while FIFO full and hold_req=1 -> next cycle FIFO empty, hold_req=0, rf_we=0.
REQ-033 Build without RF_WPORT_DEBUG_EN -> all debug_* remain 0 across REQ-028 stimulus.
